// File: rtl/simple_mul_arbiter.sv
// Round-robin arbiter sharing one SIMD multiplier among NumReq requesters, with an in-order ID FIFO routing results back.
// Optional per-requester issue counters are enabled with SIMPLE_MUL_ARB_PERF_EN.
module simple_mul_arbiter #(
    parameter int unsigned SpatPar   = 4,
    parameter int unsigned DataWidth = 64,
    parameter int unsigned NumReq    = 2,
    parameter int unsigned IdDepth   = 4
) (
    input  logic                                  clk_i,
    input  logic                                  rst_i,
    input  logic [NumReq*SpatPar*DataWidth-1:0]   req_a_i,
    input  logic [NumReq*SpatPar*DataWidth-1:0]   req_b_i,
    input  logic [NumReq-1:0]                     req_valid_i,
    output logic [NumReq-1:0]                     req_ready_o,
    output logic [NumReq*SpatPar*DataWidth-1:0]   rsp_data_o,
    output logic [NumReq-1:0]                     rsp_valid_o,
    input  logic [NumReq-1:0]                     rsp_ready_i,
    output logic [SpatPar*DataWidth-1:0]          mul_a_o,
    output logic [SpatPar*DataWidth-1:0]          mul_b_o,
    output logic                                  mul_a_valid_o,
    output logic                                  mul_b_valid_o,
    input  logic                                  mul_a_ready_i,
    input  logic                                  mul_b_ready_i,
    input  logic [SpatPar*DataWidth-1:0]          mul_result_i,
    input  logic                                  mul_result_valid_i,
    output logic                                  mul_result_ready_o,
    output logic                                  busy_o,
    output logic [NumReq*32-1:0]                  perf_cnt_o
);

    localparam int unsigned W    = SpatPar * DataWidth;
    localparam int unsigned IdW  = (NumReq > 1) ? $clog2(NumReq) : 1;
    localparam int unsigned PtrW = $clog2(IdDepth);
    localparam int unsigned CntW = PtrW + 1;

    typedef enum logic {IDLE, ISSUE} state_t;

    state_t          state_q;
    logic [IdW-1:0]  grant_q;
    logic [IdW-1:0]  rr_ptr_q;
    logic [IdW-1:0]  rr_next;
    logic            a_pend_q;
    logic            b_pend_q;

    logic            pick_found;
    logic [IdW-1:0]  pick_idx;
    int unsigned     idx;
    logic            grant_ok;
    logic            a_hs;
    logic            b_hs;
    logic            issue_done;

    logic [IdW-1:0]  id_mem [IdDepth];
    logic [PtrW-1:0] wr_ptr_q;
    logic [PtrW-1:0] rd_ptr_q;
    logic [CntW-1:0] count_q;
    logic            fifo_empty;
    logic [IdW-1:0]  head;
    logic            push;
    logic            pop;

    // First valid requester at or after rr_ptr, wrapping around.
    always_comb begin
        pick_found = 1'b0;
        pick_idx   = '0;
        idx        = 0;
        for (int unsigned i = 0; i < NumReq; i++) begin
            idx = i + 32'(rr_ptr_q);
            if (idx >= NumReq) idx = idx - NumReq;
            if (!pick_found && req_valid_i[idx]) begin
                pick_found = 1'b1;
                pick_idx   = IdW'(idx);
            end
        end
    end

    assign grant_ok   = (state_q == IDLE) && pick_found && (count_q < CntW'(IdDepth));
    assign a_hs       = a_pend_q && mul_a_ready_i;
    assign b_hs       = b_pend_q && mul_b_ready_i;
    assign issue_done = (state_q == ISSUE) && (a_hs || !a_pend_q) && (b_hs || !b_pend_q);
    assign rr_next    = (grant_q == IdW'(NumReq - 1)) ? '0 : grant_q + 1'b1;

    // The operand valids are the registered complement of a_sent/b_sent.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= IDLE;
            grant_q  <= '0;
            rr_ptr_q <= '0;
            a_pend_q <= 1'b0;
            b_pend_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (grant_ok) begin
                        grant_q  <= pick_idx;
                        a_pend_q <= 1'b1;
                        b_pend_q <= 1'b1;
                        state_q  <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (a_hs) a_pend_q <= 1'b0;
                    if (b_hs) b_pend_q <= 1'b0;
                    if (issue_done) begin
                        rr_ptr_q <= rr_next;
                        state_q  <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    always_comb begin
        mul_a_o     = '0;
        mul_b_o     = '0;
        req_ready_o = '0;
        for (int unsigned r = 0; r < NumReq; r++) begin
            if (grant_q == IdW'(r)) begin
                mul_a_o = req_a_i[r*W +: W];
                mul_b_o = req_b_i[r*W +: W];
            end
        end
        if (issue_done) req_ready_o[grant_q] = 1'b1;
    end

    assign mul_a_valid_o = a_pend_q;
    assign mul_b_valid_o = b_pend_q;

    assign fifo_empty = (count_q == '0);
    assign head       = id_mem[rd_ptr_q];
    assign push       = issue_done;
    assign pop        = mul_result_valid_i && mul_result_ready_o;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) begin
                id_mem[wr_ptr_q] <= grant_q;
                wr_ptr_q         <= wr_ptr_q + 1'b1;
            end
            if (pop) rd_ptr_q <= rd_ptr_q + 1'b1;
            if (push && !pop)      count_q <= count_q + 1'b1;
            else if (!push && pop) count_q <= count_q - 1'b1;
        end
    end

    always_comb begin
        rsp_valid_o = '0;
        if (!fifo_empty) rsp_valid_o[head] = mul_result_valid_i;
    end

    assign mul_result_ready_o = !fifo_empty && rsp_ready_i[head];
    assign rsp_data_o         = {NumReq{mul_result_i}};
    assign busy_o             = (state_q == ISSUE) || !fifo_empty;

`ifdef SIMPLE_MUL_ARB_PERF_EN
    logic [31:0] perf_q [NumReq];

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int unsigned r = 0; r < NumReq; r++) perf_q[r] <= '0;
        end else if (issue_done) begin
            perf_q[grant_q] <= perf_q[grant_q] + 32'd1;
        end
    end

    always_comb begin
        perf_cnt_o = '0;
        for (int unsigned r = 0; r < NumReq; r++) perf_cnt_o[r*32 +: 32] = perf_q[r];
    end
`else
    assign perf_cnt_o = '0;
`endif

`ifndef SYNTHESIS
    // A result with no outstanding ID means the multiplier broke ordering.
    result_has_owner: assert property (@(posedge clk_i) disable iff (rst_i)
        !(mul_result_valid_i && fifo_empty));
`endif

endmodule

// File: tb/tb_simple_mul_arbiter.sv
// Directed self-checking bench for simple_mul_arbiter with a small in-order multiplier model.
module tb_simple_mul_arbiter;

    localparam int unsigned SP = 4;
    localparam int unsigned DW = 64;
    localparam int unsigned NR = 2;
    localparam int unsigned W  = SP * DW;

    logic              clk_i = 1'b0;
    logic              rst_i = 1'b1;
    logic [NR*W-1:0]   req_a_i = '0;
    logic [NR*W-1:0]   req_b_i = '0;
    logic [NR-1:0]     req_valid_i = '0;
    logic [NR-1:0]     req_ready_o;
    logic [NR*W-1:0]   rsp_data_o;
    logic [NR-1:0]     rsp_valid_o;
    logic [NR-1:0]     rsp_ready_i = '0;
    logic [W-1:0]      mul_a_o;
    logic [W-1:0]      mul_b_o;
    logic              mul_a_valid_o;
    logic              mul_b_valid_o;
    logic              mul_a_ready_i = 1'b0;
    logic              mul_b_ready_i = 1'b0;
    logic [W-1:0]      mul_result_i = '0;
    logic              mul_result_valid_i = 1'b0;
    logic              mul_result_ready_o;
    logic              busy_o;
    logic [NR*32-1:0]  perf_cnt_o;

    int checks = 0;
    int failures = 0;

    simple_mul_arbiter #(
        .SpatPar(SP),
        .DataWidth(DW),
        .NumReq(NR),
        .IdDepth(4)
    ) dut (
        .clk_i(clk_i),
        .rst_i(rst_i),
        .req_a_i(req_a_i),
        .req_b_i(req_b_i),
        .req_valid_i(req_valid_i),
        .req_ready_o(req_ready_o),
        .rsp_data_o(rsp_data_o),
        .rsp_valid_o(rsp_valid_o),
        .rsp_ready_i(rsp_ready_i),
        .mul_a_o(mul_a_o),
        .mul_b_o(mul_b_o),
        .mul_a_valid_o(mul_a_valid_o),
        .mul_b_valid_o(mul_b_valid_o),
        .mul_a_ready_i(mul_a_ready_i),
        .mul_b_ready_i(mul_b_ready_i),
        .mul_result_i(mul_result_i),
        .mul_result_valid_i(mul_result_valid_i),
        .mul_result_ready_o(mul_result_ready_o),
        .busy_o(busy_o),
        .perf_cnt_o(perf_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    function automatic logic [W-1:0] lanes(input logic [DW-1:0] v);
        return {SP{v}};
    endfunction

    function automatic logic [W-1:0] lanemul(input logic [W-1:0] a, input logic [W-1:0] b);
        logic [W-1:0] r;
        r = '0;
        for (int l = 0; l < SP; l++) r[l*DW +: DW] = a[l*DW +: DW] * b[l*DW +: DW];
        return r;
    endfunction

    // Multiplier model: captures each operand on its own handshake, result appears one cycle later.
    logic [W-1:0] ma = '0;
    logic [W-1:0] mb = '0;
    bit           ha = 0;
    bit           hb = 0;
    logic [W-1:0] rq [$];

    always @(posedge clk_i) begin
        if (rst_i) begin
            ha = 0;
            hb = 0;
            rq.delete();
        end else begin
            if (mul_result_valid_i && mul_result_ready_o && rq.size() != 0) void'(rq.pop_front());
            if (mul_a_valid_o && mul_a_ready_i) begin ma = mul_a_o; ha = 1; end
            if (mul_b_valid_o && mul_b_ready_i) begin mb = mul_b_o; hb = 1; end
            if (ha && hb) begin
                rq.push_back(lanemul(ma, mb));
                ha = 0;
                hb = 0;
            end
        end
        mul_result_valid_i <= (rq.size() != 0);
        mul_result_i       <= (rq.size() != 0) ? rq[0] : '0;
    end

    task automatic chk(input string tag, input logic [511:0] got, input logic [511:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk_i);
        #1;
    endtask

    task automatic set_ops(input int r, input logic [DW-1:0] a, input logic [DW-1:0] b);
        req_a_i[r*W +: W] = lanes(a);
        req_b_i[r*W +: W] = lanes(b);
    endtask

    task automatic do_reset();
        rst_i         = 1'b1;
        req_valid_i   = '0;
        mul_a_ready_i = 1'b1;
        mul_b_ready_i = 1'b1;
        rsp_ready_i   = '1;
        cyc();
        cyc();
        rst_i = 1'b0;
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [NR-1:0] exp_v;
        logic [W-1:0]  exp_d;

        do_reset();
        chk("rst_req_ready", req_ready_o, 0);
        chk("rst_rsp_valid", rsp_valid_o, 0);
        chk("rst_a_valid", mul_a_valid_o, 0);
        chk("rst_b_valid", mul_b_valid_o, 0);
        chk("rst_res_ready", mul_result_ready_o, 0);
        chk("rst_busy", busy_o, 0);
        chk("rst_perf", perf_cnt_o, 0);

        // Single op from requester 0
        set_ops(0, 3, 5);
        req_valid_i = 2'b01;
        #1;
        chk("s1_idle_ready", req_ready_o, 0);
        chk("s1_idle_a_valid", mul_a_valid_o, 0);
        cyc();
        chk("s1_issue_ready", req_ready_o, 2'b01);
        chk("s1_mul_a", mul_a_o, lanes(3));
        chk("s1_mul_b", mul_b_o, lanes(5));
        chk("s1_issue_busy", busy_o, 1);
        cyc();
        req_valid_i = '0;
        #1;
        chk("s1_ready_once", req_ready_o, 0);
        chk("s1_rsp_valid", rsp_valid_o, 2'b01);
        chk("s1_rsp_data", rsp_data_o, {2{lanes(15)}});
        chk("s1_res_ready", mul_result_ready_o, 1);
        cyc();
        chk("s1_drained_valid", rsp_valid_o, 0);
        chk("s1_drained_busy", busy_o, 0);

        // Contention: alternating grants, in-order routing
        do_reset();
        set_ops(0, 2, 3);
        set_ops(1, 4, 5);
        req_valid_i = 2'b11;
        #1;
        for (int k = 0; k < 8; k++) begin
            chk("s2_idle_ready", req_ready_o, 0);
            if (k > 0) begin
                exp_v = ((k - 1) % 2 == 1) ? 2'b10 : 2'b01;
                exp_d = ((k - 1) % 2 == 1) ? lanes(20) : lanes(6);
                chk("s2_rsp_valid", rsp_valid_o, exp_v);
                chk("s2_rsp_data", rsp_data_o, {2{exp_d}});
            end
            cyc();
            exp_v = (k % 2 == 1) ? 2'b10 : 2'b01;
            chk("s2_grant", req_ready_o, exp_v);
            chk("s2_mul_a", mul_a_o, (k % 2 == 1) ? lanes(4) : lanes(2));
            cyc();
        end
        req_valid_i = '0;
        #1;
        chk("s2_last_rsp_valid", rsp_valid_o, 2'b10);
        chk("s2_last_rsp_data", rsp_data_o, {2{lanes(20)}});
`ifdef SIMPLE_MUL_ARB_PERF_EN
        chk("s2_perf", perf_cnt_o, {32'd4, 32'd4});
`else
        chk("s2_perf", perf_cnt_o, 0);
`endif
        cyc();
        chk("s2_busy_done", busy_o, 0);

        // Split handshake: b stalls three cycles
        do_reset();
        set_ops(0, 6, 7);
        req_valid_i   = 2'b01;
        mul_b_ready_i = 1'b0;
        #1;
        cyc();
        chk("s3_c1_a_valid", mul_a_valid_o, 1);
        chk("s3_c1_ready", req_ready_o, 0);
        cyc();
        chk("s3_c2_a_valid", mul_a_valid_o, 0);
        chk("s3_c2_b_valid", mul_b_valid_o, 1);
        chk("s3_c2_ready", req_ready_o, 0);
        cyc();
        chk("s3_c3_a_valid", mul_a_valid_o, 0);
        chk("s3_c3_ready", req_ready_o, 0);
        cyc();
        mul_b_ready_i = 1'b1;
        #1;
        chk("s3_b_ready_pulse", req_ready_o, 2'b01);
        chk("s3_b_cycle_a_valid", mul_a_valid_o, 0);
        cyc();
        req_valid_i = '0;
        #1;
        chk("s3_rsp_valid", rsp_valid_o, 2'b01);
        chk("s3_rsp_data", rsp_data_o, {2{lanes(42)}});
        chk("s3_ready_after", req_ready_o, 0);
        cyc();
        chk("s3_busy_done", busy_o, 0);

        // ID FIFO full: fifth request waits for one pop
        do_reset();
        rsp_ready_i = '0;
        set_ops(1, 1, 9);
        req_valid_i = 2'b10;
        #1;
        for (int k = 0; k < 4; k++) begin
            chk("s4_idle_ready", req_ready_o, 0);
            cyc();
            chk("s4_grant", req_ready_o, 2'b10);
            cyc();
        end
        chk("s4_full_busy", busy_o, 1);
        chk("s4_head_valid", rsp_valid_o, 2'b10);
        chk("s4_res_ready_held", mul_result_ready_o, 0);
        cyc();
        chk("s4_no_grant", mul_a_valid_o, 0);
        chk("s4_no_ready", req_ready_o, 0);
        rsp_ready_i = 2'b10;
        #1;
        chk("s4_pop_ready", mul_result_ready_o, 1);
        chk("s4_pop_data", rsp_data_o, {2{lanes(9)}});
        cyc();
        rsp_ready_i = '0;
        #1;
        chk("s4_arb_cycle", mul_a_valid_o, 0);
        cyc();
        chk("s4_fifth_grant", req_ready_o, 2'b10);
        chk("s4_fifth_a_valid", mul_a_valid_o, 1);
        cyc();
        req_valid_i = '0;
        rsp_ready_i = '1;
        #1;
        repeat (5) cyc();
        chk("s4_drained_busy", busy_o, 0);
        chk("s4_drained_valid", rsp_valid_o, 0);

        // Backpressure routing: head belongs to requester 1
        do_reset();
        rsp_ready_i = 2'b01;
        set_ops(1, 2, 2);
        req_valid_i = 2'b10;
        #1;
        cyc();
        chk("s5_grant", req_ready_o, 2'b10);
        cyc();
        req_valid_i = '0;
        #1;
        chk("s5_rsp_valid", rsp_valid_o, 2'b10);
        chk("s5_res_ready_blocked", mul_result_ready_o, 0);
        cyc();
        chk("s5_res_ready_still", mul_result_ready_o, 0);
        chk("s5_rsp_valid_held", rsp_valid_o, 2'b10);
        rsp_ready_i = 2'b10;
        #1;
        chk("s5_res_ready", mul_result_ready_o, 1);
        chk("s5_rsp_data", rsp_data_o, {2{lanes(4)}});
        cyc();
        chk("s5_busy_done", busy_o, 0);

        // Reset during ISSUE with operand a already sent; rr_ptr must return to 0
        do_reset();
        set_ops(0, 1, 1);
        req_valid_i = 2'b01;
        #1;
        cyc();
        chk("s6_first_grant", req_ready_o, 2'b01);
        cyc();
        req_valid_i = '0;
        #1;
        cyc();
        set_ops(1, 3, 3);
        req_valid_i   = 2'b10;
        mul_b_ready_i = 1'b0;
        #1;
        cyc();
        chk("s6_issue_a_valid", mul_a_valid_o, 1);
        cyc();
        chk("s6_a_sent", mul_a_valid_o, 0);
        chk("s6_b_pending", mul_b_valid_o, 1);
        rst_i = 1'b1;
        #1;
        cyc();
        rst_i         = 1'b0;
        req_valid_i   = 2'b11;
        mul_b_ready_i = 1'b1;
        #1;
        chk("s6_rst_a_valid", mul_a_valid_o, 0);
        chk("s6_rst_b_valid", mul_b_valid_o, 0);
        chk("s6_rst_req_ready", req_ready_o, 0);
        chk("s6_rst_rsp_valid", rsp_valid_o, 0);
        chk("s6_rst_res_ready", mul_result_ready_o, 0);
        chk("s6_rst_busy", busy_o, 0);
        cyc();
        chk("s6_grant_from_zero", req_ready_o, 2'b01);
        chk("s6_mul_a", mul_a_o, lanes(1));
        cyc();
        req_valid_i = '0;
        #1;
        cyc();
        chk("s6_busy_done", busy_o, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
